// File: rtl/cmp_pkg.sv
// cmp_pkg
// Shared definitions for the 2-bit comparator sweep checker: the sweep FSM
// state type, the number of operand vectors in one sweep, and the reference
// function giving the comparator result expected for a vector index.
package cmp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam int unsigned NUM_VECTORS = 16;

  // The vector index is {a, b}: the upper two bits are a, the lower two are b.
  // The result is one-hot {a>b, a==b, a<b} from an unsigned compare.
  function automatic logic [2:0] expected_rgb(input logic [3:0] idx);
    logic [1:0] a;
    logic [1:0] b;
    a = idx[3:2];
    b = idx[1:0];
    return {a > b, a == b, a < b};
  endfunction

endpackage

// File: rtl/settle_timer.sv
// settle_timer
// Loadable down-counter with a zero flag. The sweep checker loads it while
// presenting a new operand pair, then counts it down to time the settling
// wait before the comparator outputs are sampled.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset, clears the count
//   load       - load load_value into the counter (has priority over dec)
//   load_value - value loaded on load
//   dec        - decrement by one; holds at zero
//   zero       - high while the count is zero
module settle_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] count;

  // Load wins over decrement; the count never wraps below zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/cmp_sweep_checker.sv
// cmp_sweep_checker
// Exhaustively exercises an external 2-bit magnitude comparator. For each of
// the 16 operand pairs {a,b} it drives the operands, waits SETTLE_CYCLES
// clocks, and compares the comparator's R/G/B against the one-hot expected
// result, counting mismatches and recording the first failing index.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset
//   start      - one-cycle pulse starting a sweep (ignored unless idle)
//   R, G, B    - comparator result: a>b, a==b, a<b
//   a0, a1     - operand a bits driven to the comparator
//   b0, b1     - operand b bits driven to the comparator
//   busy       - high while vectors are being driven and checked
//   done       - one-cycle pulse when the sweep finishes
//   pass       - last completed sweep had no mismatches
//   err_count  - number of mismatching vectors (saturates at 16)
//   fail_valid - fail_idx holds the index of the first mismatch
//   fail_idx   - vector index {a,b} of the first mismatch
module cmp_sweep_checker
  import cmp_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter bit STOP_ON_FAIL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       R,
  input  logic       G,
  input  logic       B,
  output logic       a0,
  output logic       a1,
  output logic       b0,
  output logic       b1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic       fail_valid,
  output logic [3:0] fail_idx
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LAST_IDX    = 4'(NUM_VECTORS - 1);
  localparam logic [4:0] ERR_MAX     = 5'(NUM_VECTORS);

  state_t     state;
  logic [3:0] idx;
  logic       settle_zero;
  logic       mismatch;
  logic [4:0] err_next;

  settle_timer u_settle_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (state == DRIVE),
    .load_value (SETTLE_LOAD),
    .dec        (state == SETTLE),
    .zero       (settle_zero)
  );

  // Any difference from the one-hot expectation is an error, which also
  // catches comparators that assert none or several of R/G/B. err_next is
  // the count after this CHECK so pass can be decided in the same edge.
  always_comb begin
    mismatch = 1'b0;
    err_next = err_count;
    if ({R, G, B} != expected_rgb(idx)) begin
      mismatch = 1'b1;
    end
    if (mismatch && (err_count != ERR_MAX)) begin
      err_next = err_count + 5'd1;
    end
  end

  // Sweep sequencer. Operands change only in DRIVE, so they stay stable
  // through SETTLE and CHECK. done and pass are set on the edge entering
  // DONE so both are visible in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 4'd0;
      {a1, a0, b1, b0} <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 5'd0;
      fail_valid <= 1'b0;
      fail_idx   <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            idx        <= 4'd0;
            err_count  <= 5'd0;
            fail_valid <= 1'b0;
            fail_idx   <= 4'd0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            state      <= DRIVE;
          end
        end
        DRIVE: begin
          {a1, a0, b1, b0} <= idx;
          state <= SETTLE;
        end
        SETTLE: begin
          if (settle_zero) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          err_count <= err_next;
          if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_idx   <= idx;
          end
          if ((idx == LAST_IDX) || (STOP_ON_FAIL && mismatch)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 5'd0);
            state <= DONE;
          end else begin
            idx   <= idx + 4'd1;
            state <= DRIVE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_sweep_checker.sv
// tb_cmp_sweep_checker
// Drives two checkers (default and stop-on-fail) against a behavioural 2-bit
// comparator whose outputs can be corrupted per vector index by a fault mask,
// and compares sweep results with values derived from the fault pattern.
module tb_cmp_sweep_checker;

  logic clk;
  logic reset;
  logic start_m, start_s;
  logic r_m, g_m, b_m, r_s, g_s, b_s;
  logic a0_m, a1_m, b0_m, b1_m, a0_s, a1_s, b0_s, b1_s;
  logic busy_m, done_m, pass_m, fv_m, busy_s, done_s, pass_s, fv_s;
  logic [4:0] err_m, err_s;
  logic [3:0] fidx_m, fidx_s;

  logic [2:0] mask_m [16];
  logic [2:0] mask_s [16];

  int checks;
  int failures;

  cmp_sweep_checker #(.SETTLE_CYCLES(2), .STOP_ON_FAIL(1'b0)) dut (
    .clk(clk), .reset(reset), .start(start_m), .R(r_m), .G(g_m), .B(b_m),
    .a0(a0_m), .a1(a1_m), .b0(b0_m), .b1(b1_m), .busy(busy_m),
    .done(done_m), .pass(pass_m), .err_count(err_m),
    .fail_valid(fv_m), .fail_idx(fidx_m)
  );

  cmp_sweep_checker #(.SETTLE_CYCLES(2), .STOP_ON_FAIL(1'b1)) dut_stop (
    .clk(clk), .reset(reset), .start(start_s), .R(r_s), .G(g_s), .B(b_s),
    .a0(a0_s), .a1(a1_s), .b0(b0_s), .b1(b1_s), .busy(busy_s),
    .done(done_s), .pass(pass_s), .err_count(err_s),
    .fail_valid(fv_s), .fail_idx(fidx_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal comparator from plain integer arithmetic on the index {a,b}.
  function automatic logic [2:0] golden(input int i);
    int a;
    int b;
    a = i / 4;
    b = i % 4;
    return {a > b, a == b, a < b};
  endfunction

  assign {r_m, g_m, b_m} = golden(int'({a1_m, a0_m, b1_m, b0_m})) ^ mask_m[{a1_m, a0_m, b1_m, b0_m}];
  assign {r_s, g_s, b_s} = golden(int'({a1_s, a0_s, b1_s, b0_s})) ^ mask_s[{a1_s, a0_s, b1_s, b0_s}];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // kind: 0 good, 1 G stuck at 0, 2 R/B swapped, 3 R stuck at 1, 4 random
  task automatic apply_stimulus(input int sel, input int kind);
    logic [2:0] g;
    logic [2:0] f;
    for (int i = 0; i < 16; i++) begin
      g = golden(i);
      case (kind)
        1: f = {g[2], 1'b0, g[0]};
        2: f = {g[0], g[1], g[2]};
        3: f = {1'b1, g[1], g[0]};
        4: f = ($urandom_range(0, 3) == 0) ? g ^ 3'($urandom_range(1, 7)) : g;
        default: f = g;
      endcase
      if (sel == 0) mask_m[i] = g ^ f;
      else mask_s[i] = g ^ f;
    end
  endtask

  // Pulses start on the selected DUT and counts cycles until done, with an
  // optional extra start pulse while busy.
  task automatic run_sweep(input int sel, input int extra_at, output int cycles, output bit busy_ok);
    bit got;
    got = 1'b0;
    busy_ok = 1'b1;
    cycles = 0;
    @(negedge clk);
    if (sel == 0) start_m = 1'b1; else start_s = 1'b1;
    while (!got && cycles < 300) begin
      @(negedge clk);
      cycles++;
      if (sel == 0) start_m = (cycles == extra_at); else start_s = (cycles == extra_at);
      got = (sel == 0) ? done_m : done_s;
      if (!got && !((sel == 0) ? busy_m : busy_s)) busy_ok = 1'b0;
      if (got && ((sel == 0) ? busy_m : busy_s)) busy_ok = 1'b0;
    end
    start_m = 1'b0;
    start_s = 1'b0;
    check_output("sweep_timeout", 32'(got), 32'd1);
  endtask

  function automatic int model_errs(input int sel);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) if (((sel == 0) ? mask_m[i] : mask_s[i]) != 3'd0) n++;
    return n;
  endfunction

  function automatic int model_first(input int sel);
    for (int i = 0; i < 16; i++) if (((sel == 0) ? mask_m[i] : mask_s[i]) != 3'd0) return i;
    return -1;
  endfunction

  int cyc;
  bit bok;
  int n_err;
  int first;

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    start_m = 1'b0;
    start_s = 1'b0;
    apply_stimulus(0, 0);
    apply_stimulus(1, 0);
    repeat (3) @(negedge clk);
    check_output("reset_outputs_m", 32'({a1_m, a0_m, b1_m, b0_m, busy_m, done_m, pass_m, err_m, fv_m, fidx_m}), 32'd0);
    check_output("reset_outputs_s", 32'({a1_s, a0_s, b1_s, b0_s, busy_s, done_s, pass_s, err_s, fv_s, fidx_s}), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_output("idle_after_reset", 32'({busy_m, done_m, busy_s, done_s}), 32'd0);

    // Good comparator: full sweep, 65 cycles
    run_sweep(0, -1, cyc, bok);
    check_output("good_cycles", 32'(cyc), 32'd65);
    check_output("good_busy", 32'(bok), 32'd1);
    check_output("good_pass", 32'(pass_m), 32'd1);
    check_output("good_err", 32'(err_m), 32'd0);
    check_output("good_fv", 32'(fv_m), 32'd0);
    @(negedge clk);
    check_output("done_one_cycle", 32'(done_m), 32'd0);

    // G stuck at 0
    apply_stimulus(0, 1);
    run_sweep(0, -1, cyc, bok);
    check_output("gstuck_err", 32'(err_m), 32'd4);
    check_output("gstuck_fidx", 32'(fidx_m), 32'd0);
    check_output("gstuck_fv", 32'(fv_m), 32'd1);
    check_output("gstuck_pass", 32'(pass_m), 32'd0);

    // R and B swapped
    apply_stimulus(0, 2);
    run_sweep(0, -1, cyc, bok);
    check_output("swap_err", 32'(err_m), 32'd12);
    check_output("swap_fidx", 32'(fidx_m), 32'd1);
    check_output("swap_cycles", 32'(cyc), 32'd65);

    // Start during DONE is ignored
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    check_output("start_in_done_busy", 32'(busy_m), 32'd0);
    @(negedge clk);
    check_output("start_in_done_idle", 32'(busy_m), 32'd0);

    // Stop-on-fail with R stuck at 1, then a good sweep on the same DUT
    apply_stimulus(1, 3);
    run_sweep(1, -1, cyc, bok);
    check_output("stop_cycles", 32'(cyc), 32'd5);
    check_output("stop_err", 32'(err_s), 32'd1);
    check_output("stop_fidx", 32'(fidx_s), 32'd0);
    check_output("stop_fv", 32'(fv_s), 32'd1);
    apply_stimulus(1, 0);
    run_sweep(1, -1, cyc, bok);
    check_output("stop_good_cycles", 32'(cyc), 32'd65);
    check_output("stop_good_pass", 32'(pass_s), 32'd1);

    // Failing sweep, then start in the cycle after done: counters clear
    apply_stimulus(0, 1);
    run_sweep(0, -1, cyc, bok);
    apply_stimulus(0, 0);
    @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    check_output("restart_busy", 32'(busy_m), 32'd1);
    check_output("restart_err_clear", 32'({err_m, fv_m, pass_m}), 32'd0);
    cyc = 1;
    while (!done_m && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check_output("restart_cycles", 32'(cyc), 32'd65);
    check_output("restart_pass", 32'(pass_m), 32'd1);

    // Extra start while busy has no effect on timing or result
    run_sweep(0, 30, cyc, bok);
    check_output("busy_start_cycles", 32'(cyc), 32'd65);
    check_output("busy_start_busy", 32'(bok), 32'd1);
    check_output("busy_start_pass", 32'(pass_m), 32'd1);

    // Reset during SETTLE of vector 7
    apply_stimulus(0, 2);
    @(negedge clk);
    start_m = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      start_m = 1'b0;
      cyc++;
    end while ({a1_m, a0_m, b1_m, b0_m} != 4'd7 && cyc < 300);
    check_output("reach_idx7", 32'({a1_m, a0_m, b1_m, b0_m}), 32'd7);
    reset = 1'b1;
    #1;
    check_output("midreset_outputs", 32'({a1_m, a0_m, b1_m, b0_m, busy_m, done_m, pass_m, err_m, fv_m, fidx_m}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_output("midreset_idle", 32'({busy_m, done_m}), 32'd0);
    apply_stimulus(0, 0);
    run_sweep(0, -1, cyc, bok);
    check_output("post_reset_cycles", 32'(cyc), 32'd65);
    check_output("post_reset_pass", 32'(pass_m), 32'd1);

    // Random fault patterns against the mask-derived model
    for (int it = 0; it < 12; it++) begin
      apply_stimulus(0, 4);
      for (int i = 0; i < 16; i++) mask_s[i] = mask_m[i];
      n_err = model_errs(0);
      first = model_first(0);
      run_sweep(0, -1, cyc, bok);
      check_output("rnd_err", 32'(err_m), 32'(n_err));
      check_output("rnd_pass", 32'(pass_m), 32'(n_err == 0));
      check_output("rnd_fv", 32'(fv_m), 32'(n_err != 0));
      if (n_err != 0) check_output("rnd_fidx", 32'(fidx_m), 32'(first));
      run_sweep(1, -1, cyc, bok);
      check_output("rnd_stop_cycles", 32'(cyc), (n_err == 0) ? 32'd65 : 32'(4 * (first + 1) + 1));
      check_output("rnd_stop_err", 32'(err_s), 32'(n_err != 0));
      if (n_err != 0) check_output("rnd_stop_fidx", 32'(fidx_s), 32'(first));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmp_sweep_checker.md
CMP_SWEEP_CHECKER -- requirements
Module: cmp_sweep_checker

Interface
REQ-001 The block SHALL have a parameter SETTLE_CYCLES, default 2: the number of clock cycles it waits after driving operands before sampling R/G/B (range 1..15).
REQ-002 The block SHALL have a parameter STOP_ON_FAIL, default 0: when 1, the sweep ends at the first mismatch.
REQ-003 The block SHALL use a single clock, clk, as a 1-bit input; all state updates on its rising edge.
REQ-004 The block SHALL have a 1-bit input reset: asynchronous, active-high.
REQ-005 The block SHALL have a 1-bit input start: a one-cycle pulse that begins a sweep and is ignored while busy.
REQ-006 The block SHALL have four 1-bit outputs a0, a1, b0, b1: operand bits driven to the comparator, with a = {a1,a0} and b = {b1,b0}.
REQ-007 The block SHALL have three 1-bit inputs R, G, B: the comparator result, R = a>b, G = a==b, B = a<b.
REQ-008 The block SHALL have a 1-bit output busy: high while a sweep is in progress.
REQ-009 The block SHALL have a 1-bit output done: a one-cycle pulse when the sweep finishes.
REQ-010 The block SHALL have a 1-bit output pass: high when the last completed sweep had zero errors, held until the next start.
REQ-011 The block SHALL have a 5-bit output err_count: the number of mismatching vectors in the current or last sweep (0..16).
REQ-012 The block SHALL have a 1-bit output fail_valid and a 4-bit output fail_idx: fail_idx is the vector index {a,b} of the first mismatch, and is valid only when fail_valid is high.

Function
REQ-013 FSM states SHALL be IDLE, DRIVE, SETTLE, CHECK and DONE.
REQ-014 IDLE + start SHALL go to DRIVE: idx := 0, err_count := 0, fail_valid := 0, pass := 0.
REQ-015 DRIVE SHALL register {a1,a0,b1,b0} := idx (idx[3]=a1 … idx[0]=b0), load settle_cnt := SETTLE_CYCLES-1, then go to SETTLE.
REQ-016 SETTLE SHALL decrement settle_cnt and go to CHECK in the cycle it reads 0; operand outputs stay stable throughout SETTLE and CHECK.
REQ-017 In CHECK, the expected triple SHALL be computed from idx as one-hot {a>b, a==b, a<b} using unsigned 2-bit compare; a mismatch is any difference in {R,G,B}, including non-one-hot inputs.
REQ-018 On a mismatch, err_count SHALL increment by 1 (saturating at 16), and if fail_valid==0 then fail_idx := idx and fail_valid := 1.
REQ-019 From CHECK: go to DONE if idx==15, or if STOP_ON_FAIL==1 and a mismatch occurred; otherwise idx := idx+1 and go to DRIVE. idx never wraps within a sweep.
REQ-020 DONE SHALL assert done for exactly one cycle, set pass := (err_count==0 after the final CHECK), then return to IDLE.
REQ-021 busy SHALL be high in DRIVE, SETTLE and CHECK; low in IDLE and DONE.
REQ-022 Per-vector latency SHALL be 1 (DRIVE) + SETTLE_CYCLES + 1 (CHECK) cycles; a full passing sweep is 16*(SETTLE_CYCLES+2)+1 cycles from start to the done pulse.
REQ-023 A start pulse arriving in DONE or while busy SHALL be ignored; start in the cycle after done SHALL be accepted.
REQ-024 R/G/B SHALL be sampled only in CHECK; changes in any other state have no effect.

Reset
REQ-025 Asserting reset at any time, including mid-sweep, SHALL immediately force state=IDLE and all outputs 0 (a*/b* = 0, busy = 0, done = 0, pass = 0, err_count = 0, fail_valid = 0, fail_idx = 0).
REQ-026 After reset deasserts, the block SHALL remain in IDLE until a new start.

Structure
REQ-027 A shared package cmp_pkg SHALL hold the FSM state enum, the vector-count constant 16, and a function computing the expected {R,G,B} from a 4-bit index.
REQ-028 One sub-module, settle_timer (loadable down-counter with a zero flag), SHALL implement the SETTLE wait; all other logic sits in cmp_sweep_checker.

Verification
REQ-029 Bench SHALL connect a correct comparator model, pulse start with SETTLE_CYCLES=2 -> done after 65 cycles, pass=1, err_count=0, fail_valid=0.
REQ-030 Bench SHALL force G stuck at 0 -> err_count=4, fail_idx=0, fail_valid=1, pass=0.
REQ-031 Bench SHALL swap R and B in the model -> err_count=12, fail_idx=1 (a=0, b=1).
REQ-032 Bench SHALL set STOP_ON_FAIL=1 with R stuck at 1 -> done after the first CHECK (idx 0), err_count=1, fail_idx=0.
REQ-033 Bench SHALL assert reset during SETTLE of idx 7 -> all outputs 0 next edge, busy=0; a new start runs a full 16-vector sweep.
REQ-034 Bench SHALL pulse start again while busy -> no effect on idx or timing; start one cycle after done -> new sweep begins, err_count cleared.
